// File: rtl/scan_mux_jdl25175_if.sv
// Channel-mux bus: control, packed channel inputs and registered mux results.
// The master side drives control and data; the slave side is the mux itself.
interface scan_mux_jdl25175_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 1
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                     en;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_CH*DATA_W-1:0] in;
  logic [DATA_W-1:0]        out;
  logic [SEL_W-1:0]         cur_ch;
  logic                     ch_valid;
  logic                     wrap;

  modport master (
    output en, mode, sel, in,
    input  out, cur_ch, ch_valid, wrap
  );

  modport slave (
    input  en, mode, sel, in,
    output out, cur_ch, ch_valid, wrap
  );
endinterface

// File: rtl/scan_mux_jdl25175.sv
// Registered N-channel mux with enable: MANUAL follows sel, SCAN steps through
// the channels, spending DWELL cycles on each and wrapping back to channel 0.
module scan_mux_jdl25175 #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 1,
  parameter int DWELL  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  scan_mux_jdl25175_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W + 1)'(NUM_CH);
  localparam logic [DW_W-1:0]  LAST_DW  = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [SEL_W-1:0]  cur_ch_r;
  logic [SEL_W-1:0]  ch_nxt_s;
  logic [DW_W-1:0]   dwell_cnt_r;
  logic [DW_W-1:0]   dwell_nxt_s;
  logic [DATA_W-1:0] out_r;
  logic [DATA_W-1:0] out_nxt_s;
  logic              ch_valid_r;
  logic              ch_valid_nxt_s;
  logic              wrap_r;
  logic              wrap_nxt_s;
  logic              drive_s;
  logic              sel_ok_s;
  // Set while out has not been driven since reset or the last IDLE spell,
  // so the first driven cycle pulses ch_valid even on an unchanged channel.
  logic              fresh_r;

  function automatic logic [DATA_W-1:0] slice(
    input logic [NUM_CH*DATA_W-1:0] v,
    input logic [SEL_W-1:0]         ch
  );
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == SEL_W'(k)) begin
        r = v[k*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  // Next state, next channel, dwell counting and the values registered this edge
  always_comb begin
    state_nxt_s    = ST_IDLE;
    ch_nxt_s       = cur_ch_r;
    dwell_nxt_s    = dwell_cnt_r;
    drive_s        = 1'b0;
    wrap_nxt_s     = 1'b0;
    out_nxt_s      = '0;
    ch_valid_nxt_s = 1'b0;
    sel_ok_s       = ({1'b0, bus.sel} < NUM_CH_X);

    if (!bus.en) begin
      state_nxt_s = ST_IDLE;
    end else if (bus.mode) begin
      state_nxt_s = ST_SCAN;
    end else begin
      state_nxt_s = ST_MANUAL;
    end

    case (state_nxt_s)
      ST_MANUAL: begin
        dwell_nxt_s = '0;
        if (sel_ok_s) begin
          ch_nxt_s = bus.sel;
          drive_s  = 1'b1;
        end else begin
          ch_nxt_s = cur_ch_r;
          drive_s  = 1'b0;
        end
      end
      ST_SCAN: begin
        drive_s = 1'b1;
        if (state_r != ST_SCAN) begin
          dwell_nxt_s = '0;
        end else if (dwell_cnt_r == LAST_DW) begin
          dwell_nxt_s = '0;
          if (cur_ch_r == LAST_CH) begin
            ch_nxt_s   = '0;
            wrap_nxt_s = 1'b1;
          end else begin
            ch_nxt_s = cur_ch_r + SEL_W'(1);
          end
        end else begin
          dwell_nxt_s = dwell_cnt_r + DW_W'(1);
        end
      end
      ST_IDLE: begin
        drive_s = 1'b0;
      end
      default: begin
        drive_s = 1'b0;
      end
    endcase

    if (drive_s) begin
      out_nxt_s      = slice(bus.in, ch_nxt_s);
      ch_valid_nxt_s = (ch_nxt_s != cur_ch_r) || fresh_r;
    end else begin
      out_nxt_s      = '0;
      ch_valid_nxt_s = 1'b0;
    end
  end

  // State and output registers; reset overrides every input
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cur_ch_r    <= '0;
      dwell_cnt_r <= '0;
      out_r       <= '0;
      ch_valid_r  <= 1'b0;
      wrap_r      <= 1'b0;
      fresh_r     <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      cur_ch_r    <= ch_nxt_s;
      dwell_cnt_r <= dwell_nxt_s;
      out_r       <= out_nxt_s;
      ch_valid_r  <= ch_valid_nxt_s;
      wrap_r      <= wrap_nxt_s;
      if (drive_s) begin
        fresh_r <= 1'b0;
      end else if (state_nxt_s == ST_IDLE) begin
        fresh_r <= 1'b1;
      end else begin
        fresh_r <= fresh_r;
      end
    end
  end

  assign bus.out      = out_r;
  assign bus.cur_ch   = cur_ch_r;
  assign bus.ch_valid = ch_valid_r;
  assign bus.wrap     = wrap_r;
endmodule

// File: tb/tb_scan_mux_jdl25175.sv
// Directed bench: an 8x1-bit DWELL=4 mux and a 6x4-bit DWELL=1 mux,
// with hand-computed expected values for every sampled output.
module tb_scan_mux_jdl25175;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  scan_mux_jdl25175_if #(.NUM_CH(8), .DATA_W(1)) b8 ();
  scan_mux_jdl25175_if #(.NUM_CH(6), .DATA_W(4)) b6 ();

  scan_mux_jdl25175 #(.NUM_CH(8), .DATA_W(1), .DWELL(4)) dut8 (
    .clk(clk), .reset(reset), .bus(b8.slave)
  );
  scan_mux_jdl25175 #(.NUM_CH(6), .DATA_W(4), .DWELL(1)) dut6 (
    .clk(clk), .reset(reset), .bus(b6.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b8.en = 1'b1; b8.mode = 1'b1; b8.sel = 3'd0; b8.in = 8'hFF;
    b6.en = 1'b1; b6.mode = 1'b1; b6.sel = 3'd0; b6.in = 24'hFFFFFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if (b8.out !== 1'b0) begin n_err++; $display("FAIL rst_out8 cyc=%0d got=%0h exp=0", c, b8.out); end
      n_cmp++; if (b8.cur_ch !== 3'd0) begin n_err++; $display("FAIL rst_cur8 cyc=%0d got=%0d exp=0", c, b8.cur_ch); end
      n_cmp++; if (b8.ch_valid !== 1'b0) begin n_err++; $display("FAIL rst_cv8 cyc=%0d got=%0b exp=0", c, b8.ch_valid); end
      n_cmp++; if (b8.wrap !== 1'b0) begin n_err++; $display("FAIL rst_wrap8 cyc=%0d got=%0b exp=0", c, b8.wrap); end
      n_cmp++; if (b6.out !== 4'h0) begin n_err++; $display("FAIL rst_out6 cyc=%0d got=%0h exp=0", c, b6.out); end
      n_cmp++; if (b6.cur_ch !== 3'd0) begin n_err++; $display("FAIL rst_cur6 cyc=%0d got=%0d exp=0", c, b6.cur_ch); end
    end
    b6.en = 1'b0;
    b6.mode = 1'b0;
  endtask

  task automatic test_manual();
    logic [7:0] pat;
    pat = 8'b10101010;
    reset = 1'b0; b8.en = 1'b1; b8.mode = 1'b0; b8.in = pat;
    for (int s = 0; s < 8; s++) begin
      b8.sel = 3'(s);
      for (int j = 0; j < 5; j++) begin
        tick();
        n_cmp++; if (b8.out !== pat[s]) begin n_err++; $display("FAIL man_out sel=%0d j=%0d got=%0b exp=%0b", s, j, b8.out, pat[s]); end
        n_cmp++; if (b8.cur_ch !== 3'(s)) begin n_err++; $display("FAIL man_cur sel=%0d j=%0d got=%0d exp=%0d", s, j, b8.cur_ch, s); end
        n_cmp++; if (b8.ch_valid !== (j == 0)) begin n_err++; $display("FAIL man_cv sel=%0d j=%0d got=%0b exp=%0b", s, j, b8.ch_valid, (j == 0)); end
        n_cmp++; if (b8.wrap !== 1'b0) begin n_err++; $display("FAIL man_wrap sel=%0d j=%0d got=%0b exp=0", s, j, b8.wrap); end
      end
    end
  endtask

  task automatic test_scan();
    int wraps;
    int ec;
    wraps = 0;
    b8.sel = 3'd0;
    tick();
    n_cmp++; if (b8.cur_ch !== 3'd0 || b8.ch_valid !== 1'b1) begin n_err++; $display("FAIL scan_pre cur=%0d cv=%0b exp cur=0 cv=1", b8.cur_ch, b8.ch_valid); end
    b8.mode = 1'b1;
    for (int c = 0; c <= 64; c++) begin
      tick();
      ec = (c / 4) % 8;
      if (b8.wrap === 1'b1) wraps++;
      n_cmp++; if (b8.cur_ch !== 3'(ec)) begin n_err++; $display("FAIL scan_cur c=%0d got=%0d exp=%0d", c, b8.cur_ch, ec); end
      n_cmp++; if (b8.out !== 1'(ec % 2)) begin n_err++; $display("FAIL scan_out c=%0d got=%0b exp=%0b", c, b8.out, ec % 2); end
      n_cmp++; if (b8.ch_valid !== (c % 4 == 0 && c > 0)) begin n_err++; $display("FAIL scan_cv c=%0d got=%0b exp=%0b", c, b8.ch_valid, (c % 4 == 0 && c > 0)); end
      n_cmp++; if (b8.wrap !== (c % 32 == 0 && c > 0)) begin n_err++; $display("FAIL scan_wrap c=%0d got=%0b exp=%0b", c, b8.wrap, (c % 32 == 0 && c > 0)); end
    end
    n_cmp++; if (wraps != 2) begin n_err++; $display("FAIL scan_wrap_count got=%0d exp=2", wraps); end
  endtask

  task automatic test_pause();
    int ec;
    for (int c = 65; c <= 77; c++) tick();
    n_cmp++; if (b8.cur_ch !== 3'd3) begin n_err++; $display("FAIL pause_pre got=%0d exp=3", b8.cur_ch); end
    b8.en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if (b8.out !== 1'b0) begin n_err++; $display("FAIL pause_out c=%0d got=%0b exp=0", c, b8.out); end
      n_cmp++; if (b8.cur_ch !== 3'd3) begin n_err++; $display("FAIL pause_cur c=%0d got=%0d exp=3", c, b8.cur_ch); end
      n_cmp++; if (b8.ch_valid !== 1'b0) begin n_err++; $display("FAIL pause_cv c=%0d got=%0b exp=0", c, b8.ch_valid); end
    end
    b8.en = 1'b1;
    for (int d = 0; d <= 4; d++) begin
      tick();
      ec = (d < 4) ? 3 : 4;
      n_cmp++; if (b8.cur_ch !== 3'(ec)) begin n_err++; $display("FAIL resume_cur d=%0d got=%0d exp=%0d", d, b8.cur_ch, ec); end
      n_cmp++; if (b8.out !== 1'(ec % 2)) begin n_err++; $display("FAIL resume_out d=%0d got=%0b exp=%0b", d, b8.out, ec % 2); end
      n_cmp++; if (b8.ch_valid !== (d == 0 || d == 4)) begin n_err++; $display("FAIL resume_cv d=%0d got=%0b exp=%0b", d, b8.ch_valid, (d == 0 || d == 4)); end
    end
  endtask

  task automatic test_in_change();
    b8.mode = 1'b0; b8.sel = 3'd3; b8.in = 8'hAA;
    tick();
    n_cmp++; if (b8.out !== 1'b1 || b8.ch_valid !== 1'b1) begin n_err++; $display("FAIL inchg_sel out=%0b cv=%0b exp out=1 cv=1", b8.out, b8.ch_valid); end
    b8.in = 8'h00;
    tick();
    n_cmp++; if (b8.out !== 1'b0 || b8.ch_valid !== 1'b0) begin n_err++; $display("FAIL inchg_lo out=%0b cv=%0b exp out=0 cv=0", b8.out, b8.ch_valid); end
    b8.in = 8'h08;
    tick();
    n_cmp++; if (b8.out !== 1'b1 || b8.ch_valid !== 1'b0 || b8.cur_ch !== 3'd3) begin n_err++; $display("FAIL inchg_hi out=%0b cv=%0b cur=%0d exp out=1 cv=0 cur=3", b8.out, b8.ch_valid, b8.cur_ch); end
  endtask

  task automatic test_reset_mid_scan();
    int ec;
    b8.mode = 1'b0; b8.sel = 3'd5; b8.in = 8'hFF;
    tick();
    b8.mode = 1'b1;
    tick();
    tick();
    n_cmp++; if (b8.cur_ch !== 3'd5) begin n_err++; $display("FAIL rmid_pre got=%0d exp=5", b8.cur_ch); end
    reset = 1'b1;
    tick();
    n_cmp++; if (b8.out !== 1'b0) begin n_err++; $display("FAIL rmid_out got=%0b exp=0", b8.out); end
    n_cmp++; if (b8.cur_ch !== 3'd0) begin n_err++; $display("FAIL rmid_cur got=%0d exp=0", b8.cur_ch); end
    n_cmp++; if (b8.ch_valid !== 1'b0 || b8.wrap !== 1'b0) begin n_err++; $display("FAIL rmid_pulses cv=%0b wrap=%0b exp 0 0", b8.ch_valid, b8.wrap); end
    reset = 1'b0;
    for (int d = 0; d <= 4; d++) begin
      tick();
      ec = (d < 4) ? 0 : 1;
      n_cmp++; if (b8.cur_ch !== 3'(ec)) begin n_err++; $display("FAIL rmid_cur d=%0d got=%0d exp=%0d", d, b8.cur_ch, ec); end
      n_cmp++; if (b8.out !== 1'b1) begin n_err++; $display("FAIL rmid_out d=%0d got=%0b exp=1", d, b8.out); end
      n_cmp++; if (b8.ch_valid !== (d == 0 || d == 4)) begin n_err++; $display("FAIL rmid_cv d=%0d got=%0b exp=%0b", d, b8.ch_valid, (d == 0 || d == 4)); end
    end
  endtask

  task automatic test_six_ch();
    logic [3:0] exp_out [0:6];
    logic [2:0] exp_cur [0:6];
    logic       exp_cv  [0:6];
    logic       exp_wr  [0:6];
    logic [2:0] sels    [0:6];
    logic       modes   [0:6];
    // channels: 0=1 1=2 2=A 3=4 4=5 5=6
    b6.in = 24'h654A21; b6.en = 1'b1;
    sels[0] = 3'd2; modes[0] = 1'b0; exp_out[0] = 4'hA; exp_cur[0] = 3'd2; exp_cv[0] = 1'b1; exp_wr[0] = 1'b0;
    sels[1] = 3'd2; modes[1] = 1'b0; exp_out[1] = 4'hA; exp_cur[1] = 3'd2; exp_cv[1] = 1'b0; exp_wr[1] = 1'b0;
    sels[2] = 3'd7; modes[2] = 1'b0; exp_out[2] = 4'h0; exp_cur[2] = 3'd2; exp_cv[2] = 1'b0; exp_wr[2] = 1'b0;
    sels[3] = 3'd6; modes[3] = 1'b0; exp_out[3] = 4'h0; exp_cur[3] = 3'd2; exp_cv[3] = 1'b0; exp_wr[3] = 1'b0;
    sels[4] = 3'd5; modes[4] = 1'b0; exp_out[4] = 4'h6; exp_cur[4] = 3'd5; exp_cv[4] = 1'b1; exp_wr[4] = 1'b0;
    sels[5] = 3'd0; modes[5] = 1'b1; exp_out[5] = 4'h6; exp_cur[5] = 3'd5; exp_cv[5] = 1'b0; exp_wr[5] = 1'b0;
    sels[6] = 3'd0; modes[6] = 1'b1; exp_out[6] = 4'h1; exp_cur[6] = 3'd0; exp_cv[6] = 1'b1; exp_wr[6] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      b6.sel = sels[i];
      b6.mode = modes[i];
      tick();
      n_cmp++; if (b6.out !== exp_out[i]) begin n_err++; $display("FAIL six_out step=%0d got=%0h exp=%0h", i, b6.out, exp_out[i]); end
      n_cmp++; if (b6.cur_ch !== exp_cur[i]) begin n_err++; $display("FAIL six_cur step=%0d got=%0d exp=%0d", i, b6.cur_ch, exp_cur[i]); end
      n_cmp++; if (b6.ch_valid !== exp_cv[i]) begin n_err++; $display("FAIL six_cv step=%0d got=%0b exp=%0b", i, b6.ch_valid, exp_cv[i]); end
      n_cmp++; if (b6.wrap !== exp_wr[i]) begin n_err++; $display("FAIL six_wrap step=%0d got=%0b exp=%0b", i, b6.wrap, exp_wr[i]); end
    end
    tick();
    n_cmp++; if (b6.cur_ch !== 3'd1 || b6.out !== 4'h2 || b6.wrap !== 1'b0) begin n_err++; $display("FAIL six_dwell1 cur=%0d out=%0h wrap=%0b exp cur=1 out=2 wrap=0", b6.cur_ch, b6.out, b6.wrap); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_pause();
    test_in_change();
    test_reset_mid_scan();
    test_six_ch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
